pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
// Parametrised hazard/forwarding controller for the 5-stage pipeline; replaces ad-hoc DR/OP compares spread across ID/EX/MEM.
// Tracks in-flight writers from EX to WB in a DEPTH-slot shift register; resolves operand forwarding for ID.
// Generates load-use stalls, memory-wait freeze and branch flush; sits beside ID, driving FE/ID enables.
// PARAMETERS
// DATA_W      16  operand/result width
// REG_AW      3   register address width (2**REG_AW regs, no hardwired zero)
// DEPTH       3   tracked slots: 0=EX, 1=MEM, ..., DEPTH-1=WB (DEPTH>=2)
// LOAD_READY  1   first slot index whose stage_result holds load data (0<=LOAD_READY<DEPTH)
// CNT_W       16  performance counter width
// PORTS
// CLOCK_50      in   1              clock, rising edge
// reset         in   1              asynchronous, active-high
// id_valid      in   1              ID holds a real instruction
// id_sr1,id_sr2 in   REG_AW         source regs; id_sr1_used,id_sr2_used in 1: source is read
// id_dr         in   REG_AW         dest reg; id_we in 1: writes RF; id_is_load in 1: load
// rf_data1/2    in   DATA_W         register-file read data for sr1/sr2
// stage_result  in   DEPTH*DATA_W   per-slot result, slot k at [k*DATA_W +: DATA_W]
// ex_branch_taken in 1              branch resolved taken in EX this cycle
// mem_wait      in   1              data memory not ready; freeze pipeline
// opnd1,opnd2   out  DATA_W         forwarded operands to EX
// stall         out  1              hold FE/ID this cycle
// pc_wr_en      out  1              =!stall; fe_latch_wr out 1: =!stall
// flush         out  1              squash FE/ID contents (branch)
// stall_cnt     out  CNT_W          stall cycles (HAZ_PERF_CNT_EN only)
// flush_cnt     out  CNT_W          branch flushes (HAZ_PERF_CNT_EN only)
// BEHAVIOUR
// - Slot entry: {valid, we, dr, is_load}. Reset: all slots invalid; stall=0, flush=0, pc_wr_en=1, fe_latch_wr=1, counters 0.
// - match(k,s) = slot[k].valid & slot[k].we & slot[k].dr==s & s_used.
// - Forwarding (combinational): lowest k with match wins (youngest writer).
//   Use stage_result[k] if !is_load, or if is_load & k>=LOAD_READY; else no forward (stall). No match -> rf_data.
// - Load-use: lu = id_valid & any match(k,s) with is_load & k<LOAD_READY, for s in {sr1,sr2}.
// - Priority per cycle: mem_wait > ex_branch_taken > lu > normal.
//   mem_wait: slots hold, stall=1, flush=0.
//   branch: flush=1, stall=0; slot0 <= bubble (ID instr squashed); ex_branch_taken ignored while mem_wait (EX must hold it).
//   lu: stall=1; slot0 <= bubble; slots 1..DEPTH-1 shift.
//   normal: slot0 <= {id_valid, id_we, id_dr, id_is_load}; slot k <= slot k-1; WB slot retires.
// - Latency: forwarding and stall 0 cycles (same cycle as ID inputs); slot advance 1 cycle/clock.
// - Load-use stall length = LOAD_READY - k of matching load; default 1 cycle.
// - Both sources hitting different slots resolve independently; stall if either needs it.
// - id_valid=0: no stall, no forward effect; bubble enters slot0.
// - reset mid-operation: slots cleared asynchronously; in-flight hazards forgotten.
// CONFIGURATION
// HAZ_PERF_CNT_EN defined: stall_cnt +1 per cycle stall=1; flush_cnt +1 per cycle flush=1; both saturate at all-ones, cleared by reset.
// Undefined: counters not built; stall_cnt/flush_cnt tied to 0.
// TESTING (DEPTH=3, LOAD_READY=1, DATA_W=16)
// 1 ADD R2 in slot0, stage_result[0]=16'h0042; ID reads sr1=R2 -> opnd1=16'h0042, stall=0.
// 2 LD R3 in slot0; ID reads sr2=R3 -> stall=1 one cycle, pc_wr_en=0; next cycle LD in slot1, stage_result[1]=16'h1234 -> opnd2=16'h1234, stall=0.
// 3 R1 written by slot0 (16'h0001) and slot2 (16'h0002); ID reads R1 -> opnd1=16'h0001.
// 4 ex_branch_taken=1 with load-use pending -> flush=1, stall=0, slot0 bubble next cycle.
// 5 mem_wait=1 for 3 cycles -> slots frozen, stall=1 each cycle; with HAZ_PERF_CNT_EN stall_cnt=3.
// 6 reset asserted mid-stall (async) -> stall=0, slots invalid immediately, counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: ID operands/dest, RF read data, per-slot results,
// branch/mem-wait controls in; forwarded operands, stall/flush/enables, perf counters out.
// master = pipeline side driving ID state, slave = hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
);
  logic                    id_valid;
  logic [REG_AW-1:0]       id_sr1;
  logic [REG_AW-1:0]       id_sr2;
  logic                    id_sr1_used;
  logic                    id_sr2_used;
  logic [REG_AW-1:0]       id_dr;
  logic                    id_we;
  logic                    id_is_load;
  logic [DATA_W-1:0]       rf_data1;
  logic [DATA_W-1:0]       rf_data2;
  logic [DEPTH*DATA_W-1:0] stage_result;
  logic                    ex_branch_taken;
  logic                    mem_wait;
  logic [DATA_W-1:0]       opnd1;
  logic [DATA_W-1:0]       opnd2;
  logic                    stall;
  logic                    pc_wr_en;
  logic                    fe_latch_wr;
  logic                    flush;
  logic [CNT_W-1:0]        stall_cnt;
  logic [CNT_W-1:0]        flush_cnt;

  modport master (
    output id_valid, id_sr1, id_sr2, id_sr1_used, id_sr2_used, id_dr, id_we, id_is_load,
    output rf_data1, rf_data2, stage_result, ex_branch_taken, mem_wait,
    input  opnd1, opnd2, stall, pc_wr_en, fe_latch_wr, flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_sr1, id_sr2, id_sr1_used, id_sr2_used, id_dr, id_we, id_is_load,
    input  rf_data1, rf_data2, stage_result, ex_branch_taken, mem_wait,
    output opnd1, opnd2, stall, pc_wr_en, fe_latch_wr, flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: hazard/forwarding controller beside ID; tracks in-flight writers EX..WB, forwards operands, raises load-use stall, mem-wait freeze and branch flush.
// Latency: forwarding/stall/flush combinational (0 cycles); tracked slots advance one per clock.
// Backpressure: mem_wait freezes all slots and stalls FE/ID; load-use stall inserts a bubble into EX while older slots keep draining.
// Ports: CLOCK_50 (rising edge), reset (async, active-high), hz (pipe_hazard_ctrl_if.slave).
// Optional build macro: HAZ_PERF_CNT_EN adds saturating stall/flush cycle counters; otherwise they read 0.
module pipe_hazard_ctrl #(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 3,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 1,
  parameter int CNT_W      = 16
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int KW = $clog2(DEPTH);

  // Slot 0 is EX, slot DEPTH-1 is WB.
  logic [DEPTH-1:0]  slot_valid;
  logic [DEPTH-1:0]  slot_we;
  logic [DEPTH-1:0]  slot_load;
  logic [REG_AW-1:0] slot_dr [DEPTH];

  logic          hit1, hit2;
  logic [KW-1:0] idx1, idx2;
  logic          unready1, unready2;   // youngest matching writer is a load not yet holding data
  logic          lu1, lu2;             // any matching load still short of LOAD_READY
  logic          lu;
  logic          stall_i;
  logic          flush_i;
  logic          insert_id;

  // Scan oldest to youngest so the lowest matching slot is what remains.
  always_comb begin
    hit1     = 1'b0;
    hit2     = 1'b0;
    idx1     = '0;
    idx2     = '0;
    unready1 = 1'b0;
    unready2 = 1'b0;
    lu1      = 1'b0;
    lu2      = 1'b0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (slot_valid[k] && slot_we[k] && hz.id_sr1_used && (slot_dr[k] == hz.id_sr1)) begin
        hit1     = 1'b1;
        idx1     = KW'(k);
        unready1 = slot_load[k] && (k < LOAD_READY);
        if (slot_load[k] && (k < LOAD_READY)) lu1 = 1'b1;
      end
      if (slot_valid[k] && slot_we[k] && hz.id_sr2_used && (slot_dr[k] == hz.id_sr2)) begin
        hit2     = 1'b1;
        idx2     = KW'(k);
        unready2 = slot_load[k] && (k < LOAD_READY);
        if (slot_load[k] && (k < LOAD_READY)) lu2 = 1'b1;
      end
    end
  end

  // A bubble in ID neither forwards nor stalls; its operands fall back to the RF.
  assign hz.opnd1 = (hz.id_valid && hit1 && !unready1) ?
                    hz.stage_result[idx1*DATA_W +: DATA_W] : hz.rf_data1;
  assign hz.opnd2 = (hz.id_valid && hit2 && !unready2) ?
                    hz.stage_result[idx2*DATA_W +: DATA_W] : hz.rf_data2;

  assign lu = hz.id_valid && (lu1 || lu2);

  // mem_wait wins over everything; a taken branch squashes ID so its load-use is moot.
  assign flush_i   = !hz.mem_wait && hz.ex_branch_taken;
  assign stall_i   = hz.mem_wait || (!hz.ex_branch_taken && lu);
  assign insert_id = !hz.ex_branch_taken && !lu;

  assign hz.stall       = stall_i;
  assign hz.flush       = flush_i;
  assign hz.pc_wr_en    = !stall_i;
  assign hz.fe_latch_wr = !stall_i;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      slot_valid <= '0;
      slot_we    <= '0;
      slot_load  <= '0;
      for (int k = 0; k < DEPTH; k++) slot_dr[k] <= '0;
    end else if (!hz.mem_wait) begin
      for (int k = DEPTH-1; k > 0; k--) begin
        slot_valid[k] <= slot_valid[k-1];
        slot_we[k]    <= slot_we[k-1];
        slot_load[k]  <= slot_load[k-1];
        slot_dr[k]    <= slot_dr[k-1];
      end
      if (insert_id) begin
        slot_valid[0] <= hz.id_valid;
        slot_we[0]    <= hz.id_we;
        slot_load[0]  <= hz.id_is_load;
        slot_dr[0]    <= hz.id_dr;
      end else begin
        slot_valid[0] <= 1'b0;
        slot_we[0]    <= 1'b0;
        slot_load[0]  <= 1'b0;
        slot_dr[0]    <= '0;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_i && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (flush_i && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = {CNT_W{1'b0}};
  assign hz.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios plus randomized traffic checked
// against an in-flight instruction queue model.
module tb_pipe_hazard_ctrl;
  localparam int DATA_W     = 16;
  localparam int REG_AW     = 3;
  localparam int DEPTH      = 3;
  localparam int LOAD_READY = 1;
  localparam int CNT_W      = 16;
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) hz();

  pipe_hazard_ctrl #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .CNT_W(CNT_W)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst),
    .hz(hz)
  );

  typedef struct {
    bit              v;
    bit              we;
    bit [REG_AW-1:0] dr;
    bit              ld;
  } instr_t;

  instr_t fly[$];      // fly[0] = EX, fly[DEPTH-1] = WB
  int     n_chk = 0;
  int     n_err = 0;
  bit     exp_stall, exp_flush, exp_lu;
  longint exp_scnt, exp_fcnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    instr_t b;
    b = '{default: 0};
    fly.delete();
    for (int i = 0; i < DEPTH; i++) fly.push_back(b);
    exp_scnt = 0;
    exp_fcnt = 0;
  endtask

  // Youngest in-flight producer of s supplies the operand once its data exists;
  // any producing load not yet at LOAD_READY demands a stall.
  function automatic void src_eval(input bit [REG_AW-1:0] s, input bit used,
                                   input logic [DATA_W-1:0] rf,
                                   output logic [DATA_W-1:0] val, output bit need);
    bit found;
    found = 0;
    val   = rf;
    need  = 0;
    if (!hz.id_valid || !used) return;
    for (int k = 0; k < DEPTH; k++) begin
      if (fly[k].v && fly[k].we && fly[k].dr == s) begin
        if (!found && !(fly[k].ld && k < LOAD_READY))
          val = hz.stage_result[k*DATA_W +: DATA_W];
        if (fly[k].ld && k < LOAD_READY) need = 1;
        found = 1;
      end
    end
  endfunction

  task automatic settle_check();
    logic [DATA_W-1:0] e1, e2;
    bit n1, n2;
    #1;
    src_eval(hz.id_sr1, hz.id_sr1_used, hz.rf_data1, e1, n1);
    src_eval(hz.id_sr2, hz.id_sr2_used, hz.rf_data2, e2, n2);
    exp_lu    = n1 || n2;
    exp_flush = !hz.mem_wait && hz.ex_branch_taken;
    exp_stall = hz.mem_wait || (!hz.ex_branch_taken && exp_lu);
    chk("opnd1", hz.opnd1, e1);
    chk("opnd2", hz.opnd2, e2);
    chk("stall", hz.stall, exp_stall);
    chk("flush", hz.flush, exp_flush);
    chk("pc_wr_en", hz.pc_wr_en, !exp_stall);
    chk("fe_latch_wr", hz.fe_latch_wr, !exp_stall);
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cnt", hz.stall_cnt, exp_scnt);
    chk("flush_cnt", hz.flush_cnt, exp_fcnt);
`else
    chk("stall_cnt", hz.stall_cnt, 0);
    chk("flush_cnt", hz.flush_cnt, 0);
`endif
  endtask

  task automatic advance();
    instr_t e;
    @(posedge clk);
    if (!hz.mem_wait) begin
      e = '{default: 0};
      if (!hz.ex_branch_taken && !exp_lu)
        e = '{v: hz.id_valid, we: hz.id_we, dr: hz.id_dr, ld: hz.id_is_load};
      fly.push_front(e);
      void'(fly.pop_back());
    end
    if (exp_stall && exp_scnt < CNT_MAX) exp_scnt++;
    if (exp_flush && exp_fcnt < CNT_MAX) exp_fcnt++;
    @(negedge clk);
  endtask

  task automatic step();
    settle_check();
    advance();
  endtask

  task automatic set_id(input bit v, input bit [2:0] s1, input bit u1, input bit [2:0] s2,
                        input bit u2, input bit [2:0] dr, input bit we, input bit ld);
    hz.id_valid        = v;
    hz.id_sr1          = s1;
    hz.id_sr1_used     = u1;
    hz.id_sr2          = s2;
    hz.id_sr2_used     = u2;
    hz.id_dr           = dr;
    hz.id_we           = we;
    hz.id_is_load      = ld;
    hz.ex_branch_taken = 1'b0;
    hz.mem_wait        = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    hz.rf_data1     = 16'hAAAA;
    hz.rf_data2     = 16'h5555;
    hz.stage_result = '0;
    model_reset();
    #2;
    chk("rst_stall", hz.stall, 0);
    chk("rst_flush", hz.flush, 0);
    chk("rst_pc_wr_en", hz.pc_wr_en, 1);
    chk("rst_fe_latch_wr", hz.fe_latch_wr, 1);
    chk("rst_stall_cnt", hz.stall_cnt, 0);
    chk("rst_flush_cnt", hz.flush_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // ALU result forwarded from EX.
    set_id(1, 0, 0, 0, 0, 2, 1, 0); step();
    set_id(1, 2, 1, 0, 0, 0, 0, 0);
    hz.stage_result[0 +: 16] = 16'h0042;
    settle_check();
    chk("s1_opnd1", hz.opnd1, 16'h0042);
    chk("s1_stall", hz.stall, 0);
    advance();

    // Load-use: one stall, then forward from MEM.
    set_id(1, 0, 0, 0, 0, 3, 1, 1); step();
    set_id(1, 0, 0, 3, 1, 0, 0, 0);
    settle_check();
    chk("s2_stall", hz.stall, 1);
    chk("s2_pc_wr_en", hz.pc_wr_en, 0);
    advance();
    hz.stage_result[16 +: 16] = 16'h1234;
    settle_check();
    chk("s2_opnd2", hz.opnd2, 16'h1234);
    chk("s2_stall_after", hz.stall, 0);
    advance();

    // Two writers of R1: youngest wins.
    set_id(1, 0, 0, 0, 0, 1, 1, 0); step();
    set_id(1, 0, 0, 0, 0, 7, 0, 0); step();
    set_id(1, 0, 0, 0, 0, 1, 1, 0); step();
    set_id(1, 1, 1, 0, 0, 0, 0, 0);
    hz.stage_result[0 +: 16]  = 16'h0001;
    hz.stage_result[32 +: 16] = 16'h0002;
    settle_check();
    chk("s3_opnd1", hz.opnd1, 16'h0001);
    advance();

    // Branch beats pending load-use; squashed ID instr must not appear in EX.
    set_id(1, 0, 0, 0, 0, 4, 1, 1); step();
    set_id(1, 4, 1, 0, 0, 5, 1, 0);
    hz.ex_branch_taken = 1'b1;
    settle_check();
    chk("s4_flush", hz.flush, 1);
    chk("s4_stall", hz.stall, 0);
    advance();
    set_id(1, 5, 1, 0, 0, 0, 0, 0);
    settle_check();
    chk("s4_bubble_opnd1", hz.opnd1, 16'hAAAA);
    advance();

    // mem_wait freezes slots for three cycles.
    set_id(1, 0, 0, 0, 0, 6, 1, 0); step();
    set_id(1, 6, 1, 0, 0, 0, 0, 0);
    hz.stage_result[0 +: 16] = 16'h0666;
    hz.mem_wait = 1'b1;
    repeat (3) begin
      settle_check();
      chk("s5_stall", hz.stall, 1);
      chk("s5_opnd1", hz.opnd1, 16'h0666);
      advance();
    end

    // Randomized traffic.
    repeat (600) begin
      hz.id_valid        = ($urandom_range(0, 9) != 0);
      hz.id_sr1          = REG_AW'($urandom);
      hz.id_sr2          = REG_AW'($urandom);
      hz.id_sr1_used     = ($urandom_range(0, 3) != 0);
      hz.id_sr2_used     = ($urandom_range(0, 3) != 0);
      hz.id_dr           = REG_AW'($urandom);
      hz.id_we           = ($urandom_range(0, 3) != 0);
      hz.id_is_load      = ($urandom_range(0, 2) == 0);
      hz.rf_data1        = DATA_W'($urandom);
      hz.rf_data2        = DATA_W'($urandom);
      for (int k = 0; k < DEPTH; k++) hz.stage_result[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      hz.ex_branch_taken = ($urandom_range(0, 9) == 0);
      hz.mem_wait        = ($urandom_range(0, 9) == 0);
      step();
    end

    // Asynchronous reset while a load-use stall is active.
    set_id(1, 0, 0, 0, 0, 3, 1, 1); step();
    set_id(1, 3, 1, 0, 0, 0, 0, 0);
    hz.rf_data1 = 16'hAAAA;
    hz.stage_result = '0;
    settle_check();
    chk("r_stall_pre", hz.stall, 1);
    #2 rst = 1'b1;
    #1;
    chk("r_stall", hz.stall, 0);
    chk("r_pc_wr_en", hz.pc_wr_en, 1);
    chk("r_flush", hz.flush, 0);
    chk("r_opnd1", hz.opnd1, 16'hAAAA);
    chk("r_stall_cnt", hz.stall_cnt, 0);
    chk("r_flush_cnt", hz.flush_cnt, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      hz.id_valid    = ($urandom_range(0, 5) != 0);
      hz.id_sr1      = REG_AW'($urandom);
      hz.id_sr2      = REG_AW'($urandom);
      hz.id_sr1_used = 1'b1;
      hz.id_sr2_used = 1'b1;
      hz.id_dr       = REG_AW'($urandom);
      hz.id_we       = 1'b1;
      hz.id_is_load  = ($urandom_range(0, 1) == 0);
      for (int k = 0; k < DEPTH; k++) hz.stage_result[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      hz.ex_branch_taken = ($urandom_range(0, 9) == 0);
      hz.mem_wait        = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
